bcd_to_bin: RTL and testbench
=============================

Name: bcd_to_bin

Overview:
Sequential sign-magnitude BCD to two's-complement converter. It takes a sign bit and two BCD digits (tens, ones), the same form the ALU display path produces. It returns a signed 8-bit binary value using iterative reverse double-dabble (shift right, then subtract 3 from any digit that is 8 or more). It forms the operand-entry path that feeds keypad/switch BCD values back into the signed 4/8-bit arithmetic datapath, with a start/busy/done handshake.

Parameters:
- DIG_W, 4, width of each BCD digit.
- OUT_W, 8, width of the signed binary result.
- ITER, 7, number of shift iterations. 7 covers magnitudes 0..99.

Ports:
- clk  input  1  system clock, rising-edge.
- ar  input  1  asynchronous reset, active-high.
- start  input  1  request conversion. Sampled only in IDLE.
- sign_in  input  1  1 = negative operand.
- tens_in  input  4  BCD tens digit, valid 0..9.
- ones_in  input  4  BCD ones digit, valid 0..9.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when result/err are updated.
- err  output  1  set when the last accepted request had a digit greater than 9.
- result  output  8  signed two's-complement result. Held until the next done.

Behaviour:
- Reset (ar=1, async): state=IDLE, busy=0, done=0, err=0, result=8'h00, internal shift register and counter cleared. Reset mid-conversion aborts it; no done is produced.
- States: IDLE, SHIFT, SIGN.
- IDLE, start=1 at edge T, both digits ≤9:
  - Load shift reg = {tens_in, ones_in, 7'b0}.
  - Latch sign_in, counter=0.
  - Go to SHIFT. busy=1 from T. err cleared at T.
- IDLE, start=1 at edge T, either digit >9:
  - No conversion. Stay in IDLE.
  - At T: result=0, err=1, done=1 for one cycle. busy stays 0.
- SHIFT, each edge:
  - Shift the 15-bit register right by 1.
  - Then, for each BCD nibble independently, subtract 3 if the nibble is ≥8.
  - counter+1. After the ITER-th shift (edge T+7), go to SIGN.
- SIGN, edge T+8:
  - mag = low 7 bits zero-extended to 8.
  - result = sign ? (~mag + 1) : mag.
  - done=1 for exactly one cycle. busy=0. Return to IDLE.
- Latency: done is visible in the cycle after edge T+8, i.e. 9 clocks after start is sampled. Error path latency is 1 clock.
- A start during the done cycle is accepted (state is IDLE), allowing back-to-back conversions every 9 clocks.
- start while busy: ignored, no queuing. Input digits are ignored after the start edge because operands are latched.
- Negative zero (sign=1, 00) yields result 8'h00.
- Result range is -99..+99; no overflow is possible at OUT_W=8.
- err is sticky until the next accepted start.
- done and busy are never high in the same cycle.

Test Plan:
- Reset, then start with sign=0, tens=4, ones=5 -> busy for 8 cycles; done pulse 9 clocks after start; result=8'h2D, err=0.
- Start with sign=1, 9, 9 -> result=8'h9D (-99); sign=1, 0, 7 -> 8'hF9 (-7); sign=1, 0, 0 -> 8'h00.
- Start with tens=4'hA, ones=3 -> done one clock later; err=1, result=8'h00, busy never asserted. A following valid start clears err.
- Pulse start again 3 cycles into a conversion of +12 with different digits -> ignored; result=8'h0C at the original done time.
- Assert ar mid-SHIFT -> busy, done, err and result all 0 immediately (asynchronously); no done pulse after release.
- Back-to-back: start asserted in the done cycle of +27 -> second conversion (+63, 8'h3F) completes exactly 9 clocks later. Sweep all 200 sign/digit combinations against a reference model.

Source files
------------

// File: rtl/bcd_to_bin_if.sv
// Operand-entry bus for the sign-magnitude BCD to two's-complement converter.
// The requester drives start and the operand; the converter returns status and result.
interface bcd_to_bin_if #(
    parameter int DIG_W = 4,
    parameter int OUT_W = 8
);
    // Handshake: start is sampled only while busy=0; operands are captured on that
    // edge. busy is high from the accepted edge until the result is formed; done
    // pulses for one cycle when result/err update and never overlaps busy.
    logic             start;
    logic             sign_in;
    logic [DIG_W-1:0] tens_in;
    logic [DIG_W-1:0] ones_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [OUT_W-1:0] result;
    logic [1:0]       state_dbg;

    modport master (
        output start, sign_in, tens_in, ones_in,
        input  busy, done, err, result, state_dbg
    );

    modport slave (
        input  start, sign_in, tens_in, ones_in,
        output busy, done, err, result, state_dbg
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential BCD (sign, tens, ones) to signed binary converter using reverse
// double-dabble: shift right, then subtract 3 from every BCD nibble that is >= 8.
module bcd_to_bin #(
    parameter int DIG_W = 4,
    parameter int OUT_W = 8,
    parameter int ITER  = 7
) (
    input  logic         clk,
    input  logic         ar,
    bcd_to_bin_if.slave  bus
);
    localparam int SR_W  = 2 * DIG_W + ITER;
    localparam int CNT_W = $clog2(ITER + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_SIGN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [OUT_W-1:0] result_q, result_d;

    logic             digits_ok;
    logic [OUT_W-1:0] mag;

    // One iteration: after the right shift, each BCD nibble sits above the ITER
    // binary bits and is corrected independently.
    function automatic logic [SR_W-1:0] shift_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] s;
        s = sr >> 1;
        for (int i = 0; i < 2; i++) begin
            if (s[ITER + i*DIG_W +: DIG_W] >= DIG_W'(8))
                s[ITER + i*DIG_W +: DIG_W] = s[ITER + i*DIG_W +: DIG_W] - DIG_W'(3);
        end
        return s;
    endfunction

    assign digits_ok = (bus.tens_in <= DIG_W'(9)) && (bus.ones_in <= DIG_W'(9));
    assign mag       = OUT_W'(sr_q[ITER-1:0]);

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        done_d   = 1'b0;
        err_d    = err_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (digits_ok) begin
                        sr_d    = {bus.tens_in, bus.ones_in, {ITER{1'b0}}};
                        sign_d  = bus.sign_in;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_SHIFT;
                    end else begin
                        result_d = '0;
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                sr_d  = shift_step(sr_q);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1))
                    state_d = ST_SIGN;
            end
            ST_SIGN: begin
                // Negative zero naturally maps to 0 since ~0 + 1 wraps to 0.
                result_d = sign_q ? (~mag + OUT_W'(1)) : mag;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.result    = result_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: vector table, multi-cycle corner sequences
// and a full sign/digit sweep against an arithmetic reference.
module tb_bcd_to_bin;
    logic clk;
    logic ar;
    int   n_total;
    int   n_pass;
    logic [7:0] exp_q[$];

    bcd_to_bin_if #(.DIG_W(4), .OUT_W(8)) bus ();

    bcd_to_bin #(.DIG_W(4), .OUT_W(8), .ITER(7)) dut (
        .clk (clk),
        .ar  (ar),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sign;
        logic [3:0] tens;
        logic [3:0] ones;
        logic [7:0] exp_result;
        logic       exp_err;
        string      name;
    } vec_t;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [7:0] ref_conv(logic s, logic [3:0] t, logic [3:0] o);
        int m;
        m = int'(t) * 10 + int'(o);
        if (s) m = -m;
        return 8'(m);
    endfunction

    task automatic start_req(logic s, logic [3:0] t, logic [3:0] o);
        bus.sign_in = s;
        bus.tens_in = t;
        bus.ones_in = o;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
    endtask

    // Edges waited after the call until done is seen (0 if already high).
    task automatic wait_done(input int max, output int n, output logic busy_seen);
        n = 0;
        busy_seen = bus.busy;
        while (!bus.done && n < max) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.busy && bus.done) check("busy_done_overlap", 1, 0);
            if (bus.busy && !bus.done) busy_seen = 1'b1;
        end
        if (!bus.done) begin
            check("done_timeout", 0, 1);
            n = -1;
        end
    endtask

    task automatic watch_quiet(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
    endtask

    task automatic run_conv(vec_t v, input int exp_lat);
        int         n;
        logic       busy_seen;
        logic [7:0] exp_r;
        exp_q.push_back(v.exp_result);
        start_req(v.sign, v.tens, v.ones);
        wait_done(20, n, busy_seen);
        exp_r = exp_q.pop_front();
        check({v.name, "_lat"}, n, exp_lat);
        check({v.name, "_result"}, bus.result, exp_r);
        check({v.name, "_err"}, bus.err, v.exp_err);
        if (v.exp_err) check({v.name, "_busy"}, busy_seen, 0);
    endtask

    vec_t vecs[10];

    initial begin
        int   n;
        int   seen;
        logic busy_seen;
        vec_t v;
        n_total = 0;
        n_pass  = 0;

        vecs[0] = '{1'b0, 4'd4, 4'd5, 8'h2D, 1'b0, "p45"};
        vecs[1] = '{1'b1, 4'd9, 4'd9, 8'h9D, 1'b0, "n99"};
        vecs[2] = '{1'b1, 4'd0, 4'd7, 8'hF9, 1'b0, "n07"};
        vecs[3] = '{1'b1, 4'd0, 4'd0, 8'h00, 1'b0, "n00"};
        vecs[4] = '{1'b0, 4'hA, 4'd3, 8'h00, 1'b1, "errA3"};
        vecs[5] = '{1'b0, 4'd1, 4'd2, 8'h0C, 1'b0, "p12_clear"};
        vecs[6] = '{1'b0, 4'd9, 4'hF, 8'h00, 1'b1, "err9F"};
        vecs[7] = '{1'b0, 4'd9, 4'd9, 8'h63, 1'b0, "p99"};
        vecs[8] = '{1'b1, 4'hB, 4'd0, 8'h00, 1'b1, "errB0"};
        vecs[9] = '{1'b1, 4'd5, 4'd0, 8'hCE, 1'b0, "n50"};

        bus.start = 1'b0; bus.sign_in = 1'b0; bus.tens_in = '0; bus.ones_in = '0;
        ar = 1'b1;
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_result", bus.result, 8'h00);
        check("rst_state", bus.state_dbg, 0);
        @(negedge clk);
        ar = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++)
            run_conv(vecs[i], vecs[i].exp_err ? 0 : 8);

        // Busy for exactly 8 sampled cycles on a normal conversion.
        start_req(1'b0, 4'd4, 4'd5);
        seen = 1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy && !bus.done) seen++;
        end
        check("busy_len", seen, 8);
        wait_done(5, n, busy_seen);
        check("busy_len_done", n, 1);

        // Second start 3 edges in is ignored; latched operands stay in use.
        start_req(1'b0, 4'd1, 4'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.tens_in = 4'd5; bus.ones_in = 4'd5;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.tens_in = 4'd9;
        wait_done(20, n, busy_seen);
        check("ign_lat", n, 5);
        check("ign_result", bus.result, 8'h0C);
        watch_quiet(12, seen);
        check("ign_no_extra_done", seen, 0);

        // Asynchronous reset mid-shift.
        start_req(1'b0, 4'd3, 4'd3);
        @(posedge clk); #1;
        @(posedge clk); #3;
        ar = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_err", bus.err, 0);
        check("arst_result", bus.result, 8'h00);
        @(posedge clk); #1;
        ar = 1'b0;
        watch_quiet(12, seen);
        check("arst_no_done", seen, 0);

        // Back-to-back: start in the done cycle of +27.
        start_req(1'b0, 4'd2, 4'd7);
        wait_done(20, n, busy_seen);
        check("b2b_first_result", bus.result, 8'h1B);
        start_req(1'b0, 4'd6, 4'd3);
        wait_done(20, n, busy_seen);
        check("b2b_lat", n + 1, 9);
        check("b2b_result", bus.result, 8'h3F);

        // Sweep all sign/digit combinations.
        seen = 0;
        for (int s = 0; s < 2; s++)
            for (int t = 0; t < 10; t++)
                for (int o = 0; o < 10; o++) begin
                    start_req(s[0], 4'(t), 4'(o));
                    wait_done(20, n, busy_seen);
                    if (bus.result !== ref_conv(s[0], 4'(t), 4'(o)) || bus.err !== 1'b0 || n != 8) begin
                        $display("FAIL sweep_%0d_%0d%0d: got %0h err %0b lat %0d expected %0h",
                                 s, t, o, bus.result, bus.err, n, ref_conv(s[0], 4'(t), 4'(o)));
                        seen++;
                    end
                end
        check("sweep_errors", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
